// File: rtl/boot_sequencer_if.sv
// rtl/boot_sequencer_if.sv - command/response handshake between the boot sequencer and the I2C byte engine
interface boot_sequencer_if;
   logic       i2c_cmd_valid;
   logic       i2c_cmd_ready;
   logic [2:0] i2c_cmd_op;
   logic [7:0] i2c_cmd_data;
   logic [6:0] i2c_dev_addr;
   logic       i2c_rsp_valid;
   logic [7:0] i2c_rsp_data;
   logic       i2c_rsp_nack;

   modport master (
      output i2c_cmd_valid, i2c_cmd_op, i2c_cmd_data, i2c_dev_addr,
      input  i2c_cmd_ready, i2c_rsp_valid, i2c_rsp_data, i2c_rsp_nack
   );

   modport slave (
      input  i2c_cmd_valid, i2c_cmd_op, i2c_cmd_data, i2c_dev_addr,
      output i2c_cmd_ready, i2c_rsp_valid, i2c_rsp_data, i2c_rsp_nack
   );
endinterface

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads the boot image from serial EEPROM into instruction RAM and releases the CPU
module boot_sequencer #(
   parameter int unsigned IMAGE_BYTES = 256,
   parameter int unsigned ADDR_W      = 8,
   parameter logic [6:0]  DEV_ADDR    = 7'b101_0000,
   parameter int unsigned MAX_RETRIES = 3,
   parameter int unsigned RETRY_WAIT  = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   boot_sequencer_if.master  i2c,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              boot_complete,
   output logic              boot_error,
   output logic [3:0]        attempts
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_BYTES - 1);
   localparam int                WAIT_W   = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RETRY_WAIT - 1);
   localparam logic [3:0]        MAX_R    = 4'(MAX_RETRIES);

   localparam logic [2:0] OP_ADDR  = 3'd0;
   localparam logic [2:0] OP_RDSEL = 3'd1;
   localparam logic [2:0] OP_READ  = 3'd2;
   localparam logic [2:0] OP_LAST  = 3'd3;
   localparam logic [2:0] OP_STOP  = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_RDSEL, S_READ, S_WRITE, S_STOP, S_BACKOFF, S_CHECK, S_DONE, S_FAIL
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        sum_q, sum_d;
   logic [3:0]        attempts_q, attempts_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              pending_q, pending_d;
   logic [2:0]        op_q, op_d;
   logic [7:0]        data_q, data_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_wdata_q, ram_wdata_d;

   logic cmd_state;
   logic rsp;
   logic attempt_fail;

   // A response only counts once the engine has accepted our single outstanding command.
   assign cmd_state = (state_q == S_ADDR) || (state_q == S_RDSEL) ||
                      (state_q == S_READ) || (state_q == S_STOP);
   assign rsp       = pending_q && i2c.i2c_rsp_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         sum_q       <= '0;
         attempts_q  <= '0;
         wait_q      <= '0;
         cmd_valid_q <= 1'b0;
         pending_q   <= 1'b0;
         op_q        <= '0;
         data_q      <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         attempts_q  <= attempts_d;
         wait_q      <= wait_d;
         cmd_valid_q <= cmd_valid_d;
         pending_q   <= pending_d;
         op_q        <= op_d;
         data_q      <= data_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      sum_d        = sum_q;
      attempts_d   = attempts_q;
      wait_d       = wait_q;
      cmd_valid_d  = cmd_valid_q;
      pending_d    = pending_q;
      op_d         = op_q;
      data_d       = data_q;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      attempt_fail = 1'b0;

      if (cmd_state && !cmd_valid_q && !pending_q) begin
         cmd_valid_d = 1'b1;
         data_d      = 8'h00;
         case (state_q)
            S_ADDR:  op_d = OP_ADDR;
            S_RDSEL: op_d = OP_RDSEL;
            S_READ:  op_d = (idx_q == LAST_IDX) ? OP_LAST : OP_READ;
            default: op_d = OP_STOP;
         endcase
      end

      if (cmd_valid_q && i2c.i2c_cmd_ready) begin
         cmd_valid_d = 1'b0;
         pending_d   = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               sum_d   = '0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (rsp) begin
               pending_d = 1'b0;
               state_d   = i2c.i2c_rsp_nack ? S_STOP : S_RDSEL;
            end
         end
         S_RDSEL: begin
            if (rsp) begin
               pending_d = 1'b0;
               state_d   = i2c.i2c_rsp_nack ? S_STOP : S_READ;
            end
         end
         S_READ: begin
            if (rsp) begin
               pending_d   = 1'b0;
               ram_addr_d  = idx_q;
               ram_wdata_d = i2c.i2c_rsp_data;
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            sum_d = sum_q + ram_wdata_q;
            if (idx_q == LAST_IDX) begin
               state_d = S_CHECK;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = S_READ;
            end
         end
         S_STOP: begin
            if (rsp) begin
               pending_d    = 1'b0;
               attempt_fail = 1'b1;
            end
         end
         S_CHECK: begin
            if (sum_q == 8'h00) state_d = S_DONE;
            else                attempt_fail = 1'b1;
         end
         S_BACKOFF: begin
            if (wait_q == WAIT_END) begin
               idx_d   = '0;
               sum_d   = '0;
               state_d = S_ADDR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_FAIL: begin
            if (start) begin
               attempts_d = '0;
               idx_d      = '0;
               sum_d      = '0;
               state_d    = S_ADDR;
            end
         end
         default: ;
      endcase

      // Retry decision uses the count before this failure is added.
      if (attempt_fail) begin
         attempts_d = (attempts_q == 4'hF) ? 4'hF : attempts_q + 4'd1;
         wait_d     = '0;
         state_d    = (attempts_q < MAX_R) ? S_BACKOFF : S_FAIL;
      end
   end

   assign i2c.i2c_cmd_valid = cmd_valid_q;
   assign i2c.i2c_cmd_op    = op_q;
   assign i2c.i2c_cmd_data  = data_q;
   assign i2c.i2c_dev_addr  = DEV_ADDR;

   assign ram_we        = (state_q == S_WRITE);
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;
   assign cpu_hold      = (state_q != S_DONE);
   assign busy          = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
   assign boot_complete = (state_q == S_DONE);
   assign boot_error    = (state_q == S_FAIL);
   assign attempts      = attempts_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - directed bench for boot_sequencer with an EEPROM/engine model
module tb_boot_sequencer;
   localparam int IMAGE_BYTES = 4;
   localparam int ADDR_W      = 8;
   localparam int MAX_RETRIES = 2;
   localparam int RETRY_WAIT  = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              ram_we, cpu_hold, busy, boot_complete, boot_error;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic [3:0]        attempts;

   boot_sequencer_if bus ();

   boot_sequencer #(
      .IMAGE_BYTES(IMAGE_BYTES), .ADDR_W(ADDR_W), .DEV_ADDR(7'b101_0000),
      .MAX_RETRIES(MAX_RETRIES), .RETRY_WAIT(RETRY_WAIT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .i2c(bus),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .boot_complete(boot_complete),
      .boot_error(boot_error), .attempts(attempts)
   );

   always #5 clk = ~clk;

   // stimulus-owned controls for the engine model
   logic [7:0] eeprom [IMAGE_BYTES];
   int         stall_cycles = 0;
   int         spur_cnt = 0;
   int         nack_cnt = 0;

   // engine-owned state and logs
   int           spur_done = 0, nack_used = 0, rd_ptr = 0, eng_delay = 0, eng_cyc = 0;
   int           seen_wait = 0, viol = 0, op_cnt = 0, gap = -1, last_stop_cyc = 0;
   bit           eng_pend = 0, seen = 0, after_stop = 0;
   logic [2:0]   eng_op = '0, seen_op = '0;
   logic [7:0]   seen_data = '0;
   logic [127:0] op_sig = '0;

   initial begin
      bus.i2c_cmd_ready = 1'b0;
      bus.i2c_rsp_valid = 1'b0;
      bus.i2c_rsp_data  = 8'h00;
      bus.i2c_rsp_nack  = 1'b0;
      forever begin
         @(negedge clk);
         eng_cyc++;
         bus.i2c_rsp_valid = 1'b0;
         bus.i2c_rsp_nack  = 1'b0;
         if (rst) begin
            bus.i2c_cmd_ready = 1'b0;
            eng_pend = 0;
            seen     = 0;
         end else if (bus.i2c_cmd_ready) begin
            bus.i2c_cmd_ready = 1'b0;
            eng_pend  = 1;
            eng_delay = 2;
            eng_op    = seen_op;
            seen      = 0;
            op_sig    = {op_sig[123:0], 1'b0, seen_op};
            op_cnt++;
            if (bus.i2c_cmd_valid) viol++;
         end else if (eng_pend) begin
            if (bus.i2c_cmd_valid) viol++;
            eng_delay--;
            if (eng_delay == 0) begin
               eng_pend = 0;
               bus.i2c_rsp_valid = 1'b1;
               case (eng_op)
                  3'd0: begin
                     rd_ptr = 0;
                     if (nack_used < nack_cnt) begin
                        bus.i2c_rsp_nack = 1'b1;
                        nack_used++;
                     end
                  end
                  3'd2, 3'd3: begin
                     bus.i2c_rsp_data = (rd_ptr < IMAGE_BYTES) ? eeprom[rd_ptr] : 8'h00;
                     rd_ptr++;
                  end
                  3'd4: begin
                     after_stop    = 1;
                     last_stop_cyc = eng_cyc;
                  end
                  default: ;
               endcase
            end
         end else if (bus.i2c_cmd_valid) begin
            if (!seen) begin
               seen      = 1;
               seen_op   = bus.i2c_cmd_op;
               seen_data = bus.i2c_cmd_data;
               seen_wait = 0;
               if (after_stop) begin
                  gap        = eng_cyc - last_stop_cyc;
                  after_stop = 0;
               end
            end else if (bus.i2c_cmd_op !== seen_op || bus.i2c_cmd_data !== seen_data) begin
               viol++;
            end
            if (seen_wait >= stall_cycles) bus.i2c_cmd_ready = 1'b1;
            else                           seen_wait++;
         end else if (seen) begin
            viol++;
            seen = 0;
         end else if (spur_done < spur_cnt) begin
            spur_done++;
            bus.i2c_rsp_valid = 1'b1;
            bus.i2c_rsp_data  = 8'hEE;
            bus.i2c_rsp_nack  = 1'b1;
         end
      end
   end

   // RAM and completion monitor
   logic [7:0] ram [IMAGE_BYTES];
   int         wr_cnt = 0, mon_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
   logic [31:0] wr_sig = '0;
   bit         prev_done = 0;

   initial begin
      for (int i = 0; i < IMAGE_BYTES; i++) ram[i] = 8'h00;
      forever begin
         @(negedge clk);
         mon_cyc++;
         if (ram_we === 1'b1) begin
            if (int'(ram_addr) < IMAGE_BYTES) ram[ram_addr] = ram_wdata;
            wr_cnt++;
            wr_sig      = {wr_sig[23:0], ram_addr};
            last_wr_cyc = mon_cyc;
         end
         if (boot_complete === 1'b1 && !prev_done) done_cyc = mon_cyc;
         prev_done = (boot_complete === 1'b1);
      end
   end

   int passed = 0, failed = 0, total = 0;
   int b_op, b_wr, b_viol;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_flags"}, {bus.i2c_cmd_valid, ram_we, busy, boot_complete, boot_error, cpu_hold}, 6'b000001);
      chk({tag, "_regs"}, {attempts, bus.i2c_cmd_op, bus.i2c_cmd_data, ram_addr, ram_wdata}, '0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int lim);
      int n = 0;
      while (!(boot_complete === 1'b1 || boot_error === 1'b1) && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, (n < lim), 1'b1);
      @(negedge clk);
   endtask

   task automatic snap();
      b_op   = op_cnt;
      b_wr   = wr_cnt;
      b_viol = viol;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      eeprom[0] = 8'h11; eeprom[1] = 8'h22; eeprom[2] = 8'h33; eeprom[3] = 8'h9A;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("post_reset");

      // spurious response while idle
      snap();
      spur_cnt++;
      repeat (4) @(negedge clk);
      chk("idle_spur_busy", {busy, bus.i2c_cmd_valid}, 2'b00);
      chk("idle_spur_activity", {op_cnt - b_op, wr_cnt - b_wr}, 64'd0);

      // clean load
      snap();
      pulse_start();
      chk("clean_busy", busy, 1'b1);
      wait_end("clean_timeout", 300);
      chk("clean_ops", op_sig[23:0], 24'h012223);
      chk("clean_opcnt", op_cnt - b_op, 6);
      chk("clean_waddr", wr_sig, 32'h00010203);
      chk("clean_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'h1122339A);
      chk("clean_status", {boot_complete, cpu_hold, busy, boot_error, attempts}, 8'b1000_0000);
      chk("clean_done_latency", done_cyc - last_wr_cyc, 2);

      // DONE ignores start and stray responses
      snap();
      spur_cnt++;
      pulse_start();
      repeat (6) @(negedge clk);
      chk("done_ignore_activity", {op_cnt - b_op, wr_cnt - b_wr}, 64'd0);
      chk("done_ignore_status", {boot_complete, busy, cpu_hold}, 3'b100);

      // NACK on the first ADDR, then a good load
      do_reset();
      chk_reset_vals("reset2");
      snap();
      nack_cnt++;
      pulse_start();
      wait_end("nack_timeout", 400);
      chk("nack_ops", op_sig[31:0], 32'h04012223);
      chk("nack_backoff_gap", gap, RETRY_WAIT + 2);
      chk("nack_writes", {wr_cnt - b_wr, wr_sig}, {32'd4, 32'h00010203});
      chk("nack_status", {boot_complete, cpu_hold, attempts}, 6'b10_0001);

      // bad checksum on every attempt
      do_reset();
      eeprom[3] = 8'h44;
      snap();
      pulse_start();
      wait_end("bad_timeout", 800);
      chk("bad_counts", {op_cnt - b_op, wr_cnt - b_wr}, {32'd18, 32'd12});
      chk("bad_status", {boot_error, cpu_hold, busy, boot_complete, attempts}, 8'b1100_0011);
      eeprom[3] = 8'h9A;
      pulse_start();
      chk("bad_restart_clear", {boot_error, busy, attempts}, 6'b01_0000);
      wait_end("bad_reload_timeout", 300);
      chk("bad_reload_status", {boot_complete, cpu_hold, attempts}, 6'b10_0000);
      chk("bad_reload_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'h1122339A);

      // engine stalls ready for 5 cycles per command
      do_reset();
      stall_cycles = 5;
      snap();
      pulse_start();
      wait_end("stall_timeout", 600);
      stall_cycles = 0;
      chk("stall_protocol", viol - b_viol, 0);
      chk("stall_ops", {op_cnt - b_op, op_sig[23:0]}, {32'd6, 24'h012223});
      chk("stall_ram", {ram[0], ram[1], ram[2], ram[3], wr_sig}, 64'h1122339A_00010203);
      chk("stall_status", {boot_complete, cpu_hold}, 2'b10);

      // reset while reading index 2
      do_reset();
      snap();
      pulse_start();
      begin
         int n = 0;
         while (wr_cnt - b_wr < 2 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("midreset_reach_idx2", (n < 200), 1'b1);
      end
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("midreset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      snap();
      pulse_start();
      wait_end("midreset_reload_timeout", 300);
      chk("midreset_reload_ops", {op_cnt - b_op, op_sig[23:0]}, {32'd6, 24'h012223});
      chk("midreset_reload_ram", {ram[0], ram[1], ram[2], ram[3], wr_sig}, 64'h1122339A_00010203);
      chk("midreset_reload_status", {boot_complete, cpu_hold, attempts}, 6'b10_0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
